ptw_sv39: RTL

PTW_SV39 -- requirements
Module: ptw_sv39

---
 rtl/ptw_sv39.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ptw_sv39.sv
// Sv39 hardware page-table walker: three-level walk over a single-beat PTE read port.
// Optional macro PTW_AD_CHECK_EN: when defined, a leaf PTE with A=0 is reported as a page fault.
module ptw_sv39 #(
    parameter int PA_W = 56
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [26:0]     req_vpn,
    input  logic [63:0]     satp,
    input  logic            flush,
    output logic            mem_req,
    output logic [PA_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [63:0]     mem_rdata,
    output logic            resp_valid,
    output logic [43:0]     resp_ppn,
    output logic [1:0]      resp_level,
    output logic            resp_fault,
    output logic [2:0]      dbg_state
);

    // Handshake: a request transfers when req_valid & req_ready are both high on a
    // rising edge, except that a same-cycle flush wins and the request is dropped.
    // The memory side sees mem_req/mem_addr held until mem_ack; mem_ack may arrive
    // in the very cycle mem_req first rises.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        L2    = 3'd1,
        L1    = 3'd2,
        L0    = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    state_t      state, state_d;
    logic [26:0] vpn_q, vpn_d;
    logic [43:0] table_ppn, table_d;
    logic [1:0]  lvl, lvl_d;
    logic [43:0] rppn_d;
    logic [1:0]  rlvl_d;
    logic        rfault_d;

    logic        pte_v, pte_r, pte_w, pte_x;
    logic [43:0] pte_ppn;
    logic        pte_bad, pte_leaf, misalign, ad_bad, walking;
    logic [8:0]  vpn_sel;
    logic [43:0] leaf_ppn;
    logic [55:0] addr_full;
    logic        unused_bits;

    assign pte_v    = mem_rdata[0];
    assign pte_r    = mem_rdata[1];
    assign pte_w    = mem_rdata[2];
    assign pte_x    = mem_rdata[3];
    assign pte_ppn  = mem_rdata[53:10];
    assign pte_bad  = !pte_v || (!pte_r && pte_w);
    assign pte_leaf = pte_r || pte_x;
    assign misalign = ((lvl == 2'd2) && (pte_ppn[17:0] != 18'd0)) ||
                      ((lvl == 2'd1) && (pte_ppn[8:0] != 9'd0));
`ifdef PTW_AD_CHECK_EN
    assign ad_bad = !mem_rdata[6];
`else
    assign ad_bad = 1'b0;
`endif
    assign unused_bits = ^{mem_rdata[63:54], mem_rdata[9:4], satp[59:44]};

    always_comb begin
        vpn_sel  = vpn_q[8:0];
        leaf_ppn = pte_ppn;
        case (lvl)
            2'd2: begin
                vpn_sel  = vpn_q[26:18];
                leaf_ppn = {pte_ppn[43:18], vpn_q[17:9], vpn_q[8:0]};
            end
            2'd1: begin
                vpn_sel  = vpn_q[17:9];
                leaf_ppn = {pte_ppn[43:9], vpn_q[8:0]};
            end
            default: begin
                vpn_sel  = vpn_q[8:0];
                leaf_ppn = pte_ppn;
            end
        endcase
    end

    // Table base has zero low bits, so base + vpn*8 is a plain concatenation.
    assign addr_full = {table_ppn, vpn_sel, 3'b000};
    assign walking   = (state == L2) || (state == L1) || (state == L0) || (state == ABORT);
    assign mem_req   = walking;
    assign mem_addr  = walking ? PA_W'(addr_full) : '0;
    assign req_ready = (state == IDLE);
    assign resp_valid = (state == DONE) && !flush;
    assign dbg_state = state;

    always_comb begin
        state_d  = state;
        vpn_d    = vpn_q;
        table_d  = table_ppn;
        lvl_d    = lvl;
        rppn_d   = resp_ppn;
        rlvl_d   = resp_level;
        rfault_d = resp_fault;
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    vpn_d   = req_vpn;
                    table_d = satp[43:0];
                    lvl_d   = 2'd2;
                    if (satp[63:60] == 4'd0) begin
                        rppn_d   = {17'b0, req_vpn};
                        rlvl_d   = 2'd0;
                        rfault_d = 1'b0;
                        state_d  = DONE;
                    end else if (satp[63:60] == 4'd8) begin
                        state_d = L2;
                    end else begin
                        rppn_d   = 44'd0;
                        rlvl_d   = 2'd0;
                        rfault_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            L2, L1, L0: begin
                if (flush) begin
                    // Outstanding read must still complete before the port is free.
                    state_d = mem_ack ? IDLE : ABORT;
                end else if (mem_ack) begin
                    if (pte_bad || (pte_leaf && (misalign || ad_bad)) ||
                        (!pte_leaf && (lvl == 2'd0))) begin
                        rppn_d   = 44'd0;
                        rlvl_d   = lvl;
                        rfault_d = 1'b1;
                        state_d  = DONE;
                    end else if (pte_leaf) begin
                        rppn_d   = leaf_ppn;
                        rlvl_d   = lvl;
                        rfault_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        table_d = pte_ppn;
                        lvl_d   = lvl - 2'd1;
                        state_d = (lvl == 2'd2) ? L1 : L0;
                    end
                end
            end
            DONE: state_d = IDLE;
            ABORT: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vpn_q      <= 27'd0;
            table_ppn  <= 44'd0;
            lvl        <= 2'd0;
            resp_ppn   <= 44'd0;
            resp_level <= 2'd0;
            resp_fault <= 1'b0;
        end else begin
            state      <= state_d;
            vpn_q      <= vpn_d;
            table_ppn  <= table_d;
            lvl        <= lvl_d;
            resp_ppn   <= rppn_d;
            resp_level <= rlvl_d;
            resp_fault <= rfault_d;
        end
    end

endmodule
